// File: rtl/asyn_fifo_wr_arb.sv
// rtl/asyn_fifo_wr_arb.sv - round-robin burst arbiter sharing the asyn_fifo write port
// Optional stall counter output enabled by defining ASYN_FIFO_ARB_STATS_EN.
module asyn_fifo_wr_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4,
    localparam int GW        = $clog2(NUM_REQ)
) (
    input  logic                          wr_clk,
    input  logic                          wreset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          wr_en,
    input  logic                          wr_full,
    output logic [GW-1:0]                 grant_id,
    output logic                          busy
`ifdef ASYN_FIFO_ARB_STATS_EN
    ,
    output logic [15:0]                   stall_cnt
`endif
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BCNT_LAST = BW'(MAX_BURST - 1);
    localparam logic [GW-1:0] LAST_RST  = GW'(NUM_REQ - 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   last, last_nxt, grant_nxt;
    logic [BW-1:0]   bcnt, bcnt_nxt;
    logic [GW-1:0]   winner, cand;
    logic            any_valid;
    logic            cur_valid, beat, burst_end;
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Search starts one past the last winner, so the previous holder ranks lowest.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = GW'((int'(last) + i) % NUM_REQ);
            if (!any_valid && req_valid[cand]) begin
                any_valid = 1'b1;
                winner    = cand;
            end
        end
    end

    assign cur_valid = req_valid[grant_id];
    assign beat      = (state == BURST) && cur_valid && !wr_full;
    assign burst_end = (state == BURST) && (!cur_valid || (beat && (bcnt == BCNT_LAST)));
    assign busy      = (state == BURST);

    always_ff @(posedge wr_clk or posedge wreset) begin
        if (wreset) begin
            state    <= IDLE;
            grant_id <= '0;
            last     <= LAST_RST;
            bcnt     <= '0;
        end else begin
            state    <= state_nxt;
            grant_id <= grant_nxt;
            last     <= last_nxt;
            bcnt     <= bcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        last_nxt  = last;
        bcnt_nxt  = bcnt;
        req_ready = '0;
        wr_en     = 1'b0;
        wr_data   = '0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    state_nxt = BURST;
                    grant_nxt = winner;
                    last_nxt  = winner;
                    bcnt_nxt  = '0;
                end
            end
            BURST: begin
                if (beat) begin
                    req_ready[grant_id] = 1'b1;
                    wr_en               = 1'b1;
                    wr_data             = data_arr[grant_id];
                end
                if (burst_end) begin
                    bcnt_nxt = '0;
                    if (any_valid) begin
                        grant_nxt = winner;
                        last_nxt  = winner;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (beat) begin
                    bcnt_nxt = bcnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef ASYN_FIFO_ARB_STATS_EN
    // Counts cycles the granted requester is held off by a full FIFO.
    always_ff @(posedge wr_clk or posedge wreset) begin
        if (wreset) begin
            stall_cnt <= '0;
        end else if ((state == BURST) && cur_valid && wr_full && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_asyn_fifo_wr_arb.sv
// tb/tb_asyn_fifo_wr_arb.sv - self-checking bench for asyn_fifo_wr_arb
// Table vectors for stall/drop corners, directed bursts, reset abort and a random scoreboard run.
module tb_asyn_fifo_wr_arb;
    localparam int NR = 4;
    localparam int DW = 32;
    localparam int MB = 4;

    logic            wr_clk = 1'b0;
    logic            wreset;
    logic [NR-1:0]   req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic [DW-1:0]   wr_data;
    logic            wr_en;
    logic            wr_full;
    logic [1:0]      grant_id;
    logic            busy;
`ifdef ASYN_FIFO_ARB_STATS_EN
    logic [15:0]     stall_cnt;
`endif

    asyn_fifo_wr_arb #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .wr_clk(wr_clk),
        .wreset(wreset),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .wr_data(wr_data),
        .wr_en(wr_en),
        .wr_full(wr_full),
        .grant_id(grant_id),
        .busy(busy)
`ifdef ASYN_FIFO_ARB_STATS_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 wr_clk = ~wr_clk;

    typedef struct packed {
        logic       rst;
        logic [3:0] rv;
        logic       full;
        logic       en;
        logic [3:0] rdy;
        logic [1:0] gid;
        logic       bsy;
    } vec_t;

    vec_t        tbl [0:16];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] src_q [NR][$];
    logic [31:0] exp_q [NR][$];
    int          got_id [$];
    int          seq [NR];
    int          wait_cnt [NR];
    logic        s_en, s_busy;
    logic [1:0]  s_gid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    function automatic logic [31:0] tdata(input int i);
        return 32'hD000_0000 | (i * 32'h111);
    endfunction

    task automatic push_beat(input int i);
        logic [31:0] d;
        seq[i]++;
        d = {8'(i + 1), 24'(seq[i])};
        src_q[i].push_back(d);
        exp_q[i].push_back(d);
    endtask

    task automatic do_reset(input logic clear);
        req_valid = '0;
        wr_full   = 1'b0;
        wreset    = 1'b1;
        if (clear) begin
            for (int i = 0; i < NR; i++) begin
                src_q[i].delete();
                exp_q[i].delete();
                wait_cnt[i] = 0;
            end
        end
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_grant_id", grant_id, 0);
        @(posedge wr_clk);
        @(posedge wr_clk);
        #1;
        wreset = 1'b0;
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            if (src_q[i].size() > 0) begin
                req_valid[i]         = 1'b1;
                req_data[i*DW +: DW] = src_q[i][0];
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic monitor();
        int gi;
        logic [31:0] tmp;
        s_en   = wr_en;
        s_busy = busy;
        s_gid  = grant_id;
        gi     = int'(grant_id);
        chk("en_while_full", {31'b0, wr_en & wr_full}, 0);
        chk("ready_vs_en", {31'b0, |req_ready}, {31'b0, wr_en});
        if (wr_en) begin
            chk("ready_onehot", {28'b0, req_ready}, 32'd1 << gi);
            if (exp_q[gi].size() == 0) begin
                chk("unexpected_beat", 1, 0);
            end else begin
                tmp = exp_q[gi].pop_front();
                chk("data_order", wr_data, tmp);
            end
            if (src_q[gi].size() > 0) tmp = src_q[gi].pop_front();
            got_id.push_back(gi);
        end
        for (int j = 0; j < NR; j++) begin
            if (!req_valid[j] || (wr_en && j == gi)) begin
                wait_cnt[j] = 0;
            end else if (wr_en) begin
                wait_cnt[j]++;
                chk("wait_bound", {31'b0, wait_cnt[j] <= (NR - 1) * MB}, 1);
            end
        end
    endtask

    task automatic run_cycle(input logic full_in);
        drive();
        wr_full = full_in;
        @(negedge wr_clk);
        monitor();
        @(posedge wr_clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nbeat, first_c, last_c, rand_beats;
        logic found;
        for (int i = 0; i < NR; i++) begin
            seq[i]      = 0;
            wait_cnt[i] = 0;
        end
        req_data = '0;
        do_reset(1'b1);

        // requester 1 stalled by full for 5 cycles, then requester 0 drops valid while 3 waits
        tbl[0]  = '{1'b1, 4'b0010, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[1]  = '{1'b0, 4'b0010, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1};
        tbl[2]  = '{1'b0, 4'b0010, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1};
        for (int k = 3; k <= 7; k++)
            tbl[k] = '{1'b0, 4'b0010, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b1};
        tbl[8]  = '{1'b0, 4'b0010, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1};
        tbl[9]  = '{1'b0, 4'b0010, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1};
        tbl[10] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b1};
        tbl[11] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0};
        tbl[12] = '{1'b1, 4'b1001, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[13] = '{1'b0, 4'b1001, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1};
        tbl[14] = '{1'b0, 4'b1000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b1};
        tbl[15] = '{1'b0, 4'b1000, 1'b0, 1'b1, 4'b1000, 2'd3, 1'b1};
        tbl[16] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b1};
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = tdata(i);
        for (int k = 0; k < 17; k++) begin
            if (tbl[k].rst) do_reset(1'b1);
            req_valid = tbl[k].rv;
            wr_full   = tbl[k].full;
            @(negedge wr_clk);
            chk($sformatf("tbl%0d_wr_en", k), wr_en, tbl[k].en);
            chk($sformatf("tbl%0d_req_ready", k), req_ready, tbl[k].rdy);
            chk($sformatf("tbl%0d_grant_id", k), grant_id, tbl[k].gid);
            chk($sformatf("tbl%0d_busy", k), busy, tbl[k].bsy);
            if (tbl[k].en) chk($sformatf("tbl%0d_wr_data", k), wr_data, tdata(int'(tbl[k].gid)));
`ifdef ASYN_FIFO_ARB_STATS_EN
            if (k == 11) chk("stall_cnt", stall_cnt, 5);
`endif
            @(posedge wr_clk);
            #1;
        end

        // all four requesters valid continuously
        do_reset(1'b1);
        got_id.delete();
        for (int i = 0; i < NR; i++)
            for (int k = 0; k < 8; k++) push_beat(i);
        for (int c = 0; c < 18; c++) begin
            run_cycle(1'b0);
            if (c == 0) begin
                chk("rr_first_wr_en", s_en, 0);
                chk("rr_first_busy", s_busy, 0);
            end else begin
                chk($sformatf("rr_c%0d_wr_en", c), s_en, 1);
                chk($sformatf("rr_c%0d_grant", c), s_gid, (c <= 16) ? (c - 1) / 4 : 0);
            end
        end
        chk("rr_beat_count", got_id.size(), 17);
        if (got_id.size() >= 16)
            for (int k = 0; k < 16; k++) chk($sformatf("rr_order%0d", k), got_id[k], k / 4);

        // only requester 2, ten beats back to back
        do_reset(1'b1);
        for (int k = 0; k < 10; k++) push_beat(2);
        nbeat = 0; first_c = 0; last_c = 0;
        for (int c = 0; c < 40 && nbeat < 10; c++) begin
            run_cycle(1'b0);
            if (s_en) begin
                if (nbeat == 0) first_c = c;
                last_c = c;
                nbeat++;
                chk("r2_grant", s_gid, 2);
            end
        end
        chk("r2_beats", nbeat, 10);
        chk("r2_no_bubble", last_c - first_c + 1, 10);
        run_cycle(1'b0);
        chk("r2_after_wr_en", s_en, 0);
        run_cycle(1'b0);
        chk("r2_idle_busy", s_busy, 0);

        // reset in the middle of requester 0's burst
        do_reset(1'b1);
        got_id.delete();
        for (int k = 0; k < 4; k++) begin
            push_beat(0);
            push_beat(1);
        end
        for (int c = 0; c < 3; c++) run_cycle(1'b0);
        chk("midrst_beats_done", got_id.size(), 2);
        drive();
        #1;
        chk("midrst_pre_busy", busy, 1);
        wreset = 1'b1;
        #1;
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_req_ready", req_ready, 0);
        chk("midrst_busy", busy, 0);
        @(posedge wr_clk);
        #1;
        wreset = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            run_cycle(1'b0);
            if (s_en) begin
                found = 1'b1;
                chk("midrst_priority", s_gid, 0);
            end
        end
        chk("midrst_beat_seen", found, 1);

        // random valid/full mix
        do_reset(1'b1);
        rand_beats = 0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NR; i++)
                if (src_q[i].size() < 6 && $urandom_range(0, 3) == 0) push_beat(i);
            run_cycle($urandom_range(0, 3) == 0);
            if (s_en) rand_beats++;
        end
        chk("rand_progress", {31'b0, rand_beats > 500}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
